// File: rtl/pellet_spawner.sv
// rtl/pellet_spawner.sv - pellet slot table with retrying random spawn and eat clear
// Optional feature macro: PELLET_DUP_CHECK_EN (reject candidates that land on a live pellet).
module pellet_spawner #(
  parameter  int NUM_PELLETS = 8,
  parameter  int X_W         = 8,
  parameter  int Y_W         = 7,
  parameter  int MAX_TRIES   = 4,
  localparam int IDX_W       = (NUM_PELLETS > 1) ? $clog2(NUM_PELLETS) : 1,
  localparam int CNT_W       = $clog2(NUM_PELLETS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [X_W-1:0]   rand_x,
  input  logic [Y_W-1:0]   rand_y,
  output logic [X_W-1:0]   map_x,
  output logic [Y_W-1:0]   map_y,
  input  logic             map_q,
  input  logic             spawn_req,
  output logic             busy,
  output logic             spawn_done,
  output logic             spawn_ok,
  input  logic             eat_valid,
  input  logic [X_W-1:0]   eat_x,
  input  logic [Y_W-1:0]   eat_y,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_valid,
  output logic [CNT_W-1:0] pellet_count
);

  localparam int TRY_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                 state_q;
  logic [X_W-1:0]         cand_x_q;
  logic [Y_W-1:0]         cand_y_q;
  logic [TRY_W-1:0]       tries_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ok_q;

  logic [NUM_PELLETS-1:0] valid_q;
  logic [NUM_PELLETS-1:0] valid_d;
  logic [X_W-1:0]         slot_x_q [NUM_PELLETS];
  logic [Y_W-1:0]         slot_y_q [NUM_PELLETS];
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  logic                   has_free;
  logic [IDX_W-1:0]       free_idx;
  logic                   dup;
  logic                   accept;
  logic [NUM_PELLETS-1:0] eat_clear;

  // Free-slot search, duplicate detection and eat matching all look at the
  // pre-eat table, so a write never lands on a slot being cleared.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_PELLETS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end

    dup = 1'b0;
`ifdef PELLET_DUP_CHECK_EN
    for (int i = 0; i < NUM_PELLETS; i++) begin
      if (valid_q[i] && slot_x_q[i] == cand_x_q && slot_y_q[i] == cand_y_q) begin
        dup = 1'b1;
      end
    end
`else
    dup = 1'b0;
`endif

    accept = (state_q == S_CHECK) && map_q && !dup && has_free;

    for (int i = 0; i < NUM_PELLETS; i++) begin
      eat_clear[i] = eat_valid && valid_q[i] &&
                     slot_x_q[i] == eat_x && slot_y_q[i] == eat_y;
    end

    valid_d = valid_q & ~eat_clear;
    if (accept) begin
      valid_d[free_idx] = 1'b1;
    end

    count_d = '0;
    for (int i = 0; i < NUM_PELLETS; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cand_x_q <= '1;
      cand_y_q <= '1;
      tries_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (spawn_req) begin
            busy_q <= 1'b1;
            if (has_free) begin
              cand_x_q <= rand_x;
              cand_y_q <= rand_y;
              tries_q  <= TRY_W'(1);
              state_q  <= S_CHECK;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            done_q  <= 1'b1;
            ok_q    <= 1'b1;
            state_q <= S_FINISH;
          end else if (tries_q == TRY_W'(MAX_TRIES)) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            cand_x_q <= rand_x;
            cand_y_q <= rand_y;
            tries_q  <= tries_q + TRY_W'(1);
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_PELLETS; i++) begin
        slot_x_q[i] <= '1;
        slot_y_q[i] <= '1;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (accept) begin
        slot_x_q[free_idx] <= cand_x_q;
        slot_y_q[free_idx] <= cand_y_q;
      end
    end
  end

  assign map_x        = cand_x_q;
  assign map_y        = cand_y_q;
  assign busy         = busy_q;
  assign spawn_done   = done_q;
  assign spawn_ok     = ok_q;
  assign rd_x         = slot_x_q[rd_idx];
  assign rd_y         = slot_y_q[rd_idx];
  assign rd_valid     = valid_q[rd_idx];
  assign pellet_count = count_q;

endmodule

// File: tb/tb_pellet_spawner.sv
// tb/tb_pellet_spawner.sv - directed and randomized bench for pellet_spawner
// Honors PELLET_DUP_CHECK_EN the same way as the design.
module tb_pellet_spawner;

  localparam int NP = 8;
  localparam int MT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rand_x;
  logic [6:0] rand_y;
  logic [7:0] map_x;
  logic [6:0] map_y;
  logic       map_q;
  logic       spawn_req;
  logic       busy;
  logic       spawn_done;
  logic       spawn_ok;
  logic       eat_valid;
  logic [7:0] eat_x;
  logic [6:0] eat_y;
  logic [2:0] rd_idx;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_valid;
  logic [3:0] pellet_count;

  logic [1:0] map_mode;

  always #10 clock = ~clock;

  // Maze stand-in: mode 0 all walls, mode 1 all open, mode 2 even x open.
  assign map_q = (map_mode == 2'd1) | ((map_mode == 2'd2) & ~map_x[0]);

  pellet_spawner dut (
    .clock(clock), .reset(reset),
    .rand_x(rand_x), .rand_y(rand_y),
    .map_x(map_x), .map_y(map_y), .map_q(map_q),
    .spawn_req(spawn_req), .busy(busy),
    .spawn_done(spawn_done), .spawn_ok(spawn_ok),
    .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
    .pellet_count(pellet_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit         mvalid [NP];
  logic [7:0] mx     [NP];
  logic [6:0] my     [NP];
  logic [7:0] cxa    [16];
  logic [6:0] cya    [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_open(input logic [7:0] x);
    return (map_mode == 2'd1) || (map_mode == 2'd2 && x[0] == 1'b0);
  endfunction

  function automatic bit m_dup(input logic [7:0] x, input logic [6:0] y);
    bit d = 1'b0;
`ifdef PELLET_DUP_CHECK_EN
    for (int i = 0; i < NP; i++) if (mvalid[i] && mx[i] == x && my[i] == y) d = 1'b1;
`endif
    return d;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NP; i++) c += int'(mvalid[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      mvalid[i] = 1'b0;
      mx[i] = 8'hFF;
      my[i] = 7'h7F;
    end
  endtask

  task automatic fill_cands(input logic [7:0] x, input logic [6:0] y);
    for (int j = 0; j < 16; j++) begin
      cxa[j] = x;
      cya[j] = y;
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < NP; i++) begin
      rd_idx = 3'(i);
      #1;
      chk({tag, "_valid"}, 32'(rd_valid), 32'(mvalid[i]));
      if (mvalid[i]) begin
        chk({tag, "_x"}, 32'(rd_x), 32'(mx[i]));
        chk({tag, "_y"}, 32'(rd_y), 32'(my[i]));
      end
    end
    chk({tag, "_count"}, 32'(pellet_count), 32'(m_count()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spawn_req = 1'b0;
    eat_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Requests one pellet using candidates cxa/cya; optional eat lands on the
  // final (deciding) edge of the request.
  task automatic do_spawn(input string tag, input bit eat_en,
                          input logic [7:0] ex, input logic [6:0] ey);
    int  free_slot;
    int  exp_n;
    int  n;
    bit  exp_ok;
    bit  seen;
    free_slot = -1;
    for (int i = NP - 1; i >= 0; i--) if (!mvalid[i]) free_slot = i;
    exp_ok = 1'b0;
    if (free_slot < 0) begin
      exp_n = 1;
    end else begin
      exp_n = 1 + MT;
      for (int k = MT - 1; k >= 0; k--) begin
        if (m_open(cxa[k]) && !m_dup(cxa[k], cya[k])) begin
          exp_ok = 1'b1;
          exp_n  = k + 2;
        end
      end
    end

    spawn_req = 1'b1;
    rand_x = cxa[0];
    rand_y = cya[0];
    if (eat_en && exp_n == 1) begin
      eat_valid = 1'b1; eat_x = ex; eat_y = ey;
    end
    seen = 1'b0;
    n = 0;
    while (!seen && n < exp_n + 3) begin
      @(posedge clock);
      #1;
      n++;
      spawn_req = 1'b0;
      eat_valid = 1'b0;
      if (spawn_done) begin
        seen = 1'b1;
      end else begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        rand_x = cxa[n];
        rand_y = cya[n];
        if (eat_en && n == exp_n - 1) begin
          eat_valid = 1'b1; eat_x = ex; eat_y = ey;
        end
      end
    end
    chk({tag, "_latency"}, seen ? 32'(n) : 32'd0, 32'(exp_n));
    chk({tag, "_ok"}, 32'(spawn_ok), 32'(exp_ok));

    if (eat_en) begin
      for (int i = 0; i < NP; i++) if (mvalid[i] && mx[i] == ex && my[i] == ey) mvalid[i] = 1'b0;
    end
    if (exp_ok) begin
      mvalid[free_slot] = 1'b1;
      mx[free_slot] = cxa[exp_n - 2];
      my[free_slot] = cya[exp_n - 2];
    end

    @(posedge clock);
    #1;
    chk({tag, "_pulse_end"}, 32'(spawn_done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    check_table(tag);
  endtask

  task automatic do_eat(input string tag, input logic [7:0] ex, input logic [6:0] ey);
    eat_valid = 1'b1;
    eat_x = ex;
    eat_y = ey;
    @(posedge clock);
    #1;
    eat_valid = 1'b0;
    for (int i = 0; i < NP; i++) if (mvalid[i] && mx[i] == ex && my[i] == ey) mvalid[i] = 1'b0;
    check_table(tag);
  endtask

  initial begin
    reset = 1'b1; spawn_req = 1'b0; eat_valid = 1'b0;
    eat_x = '0; eat_y = '0; rand_x = '0; rand_y = '0; rd_idx = '0;
    map_mode = 2'd1;
    model_clear();

    // Reset state
    do_reset();
    rd_idx = 3'd0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(spawn_done), 32'd0);
    chk("rst_ok", 32'(spawn_ok), 32'd0);
    chk("rst_count", 32'(pellet_count), 32'd0);
    chk("rst_rd_x", 32'(rd_x), 32'hFF);
    chk("rst_rd_y", 32'(rd_y), 32'h7F);
    chk("rst_map_x", 32'(map_x), 32'hFF);
    check_table("rst");

    // First-try accept
    map_mode = 2'd1;
    fill_cands(8'd10, 7'd20);
    do_spawn("t1", 1'b0, '0, '0);
    rd_idx = 3'd0;
    #1;
    chk("t1_slot0_x", 32'(rd_x), 32'd10);
    chk("t1_slot0_y", 32'(rd_y), 32'd20);

    // Three walls then an open tile; then walls only
    map_mode = 2'd2;
    fill_cands(8'd6, 7'd5);
    cxa[0] = 8'd1; cxa[1] = 8'd3; cxa[2] = 8'd5;
    do_spawn("t2_retry", 1'b0, '0, '0);
    map_mode = 2'd0;
    do_spawn("t2_fail", 1'b0, '0, '0);

    // Full table
    do_reset();
    map_mode = 2'd1;
    for (int i = 0; i < NP; i++) begin
      fill_cands(8'(2 * i), 7'(i));
      do_spawn("t3_fill", 1'b0, '0, '0);
    end
    fill_cands(8'd100, 7'd100);
    do_spawn("t3_full", 1'b0, '0, '0);
    chk("t3_count", 32'(pellet_count), 32'd8);

    // Eat then refill the freed slot
    do_reset();
    fill_cands(8'd10, 7'd20);
    do_spawn("t4_a", 1'b0, '0, '0);
    fill_cands(8'd30, 7'd40);
    do_spawn("t4_b", 1'b0, '0, '0);
    do_eat("t4_eat", 8'd10, 7'd20);
    chk("t4_count", 32'(pellet_count), 32'd1);
    fill_cands(8'd50, 7'd60);
    do_spawn("t4_refill", 1'b0, '0, '0);
    rd_idx = 3'd0;
    #1;
    chk("t4_slot0_x", 32'(rd_x), 32'd50);
    chk("t4_slot0_valid", 32'(rd_valid), 32'd1);

    // Same tile twice
    do_reset();
    fill_cands(8'd10, 7'd20);
    do_spawn("t5_first", 1'b0, '0, '0);
    do_spawn("t5_same", 1'b0, '0, '0);
`ifdef PELLET_DUP_CHECK_EN
    chk("t5_count", 32'(pellet_count), 32'd1);
`else
    chk("t5_count", 32'(pellet_count), 32'd2);
`endif

    // Write and eat on the same edge
    fill_cands(8'd12, 7'd3);
    do_spawn("t5_eatwr", 1'b1, 8'd10, 7'd20);

    // Reset during CHECK
    map_mode = 2'd0;
    fill_cands(8'd7, 7'd7);
    spawn_req = 1'b1;
    @(posedge clock);
    #1;
    spawn_req = 1'b0;
    chk("t6_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    chk("t6_done", 32'(spawn_done), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_count", 32'(pellet_count), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      chk("t6_no_pulse", 32'(spawn_done), 32'd0);
    end
    check_table("t6");

    // Randomized spawn/eat traffic on a small coordinate pool
    map_mode = 2'd2;
    for (int it = 0; it < 60; it++) begin
      int         r;
      int         pick;
      logic [7:0] ex;
      logic [6:0] ey;
      r    = int'($urandom_range(0, 9));
      pick = int'($urandom_range(0, NP - 1));
      ex   = mx[pick];
      ey   = my[pick];
      if (r < 7) begin
        for (int j = 0; j < 16; j++) begin
          cxa[j] = 8'($urandom_range(0, 5));
          cya[j] = 7'($urandom_range(0, 2));
        end
        do_spawn("rnd_spawn", r < 2, ex, ey);
      end else begin
        do_eat("rnd_eat", ex, ey);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
